// File: rtl/stopwatch_counter_if.sv
// Button/tick inputs and BCD display outputs of the stopwatch core.
// The bench or panel logic uses master; the core uses slave.
interface stopwatch_counter_if;
  logic       tick_in;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] cs_tens;
  logic [3:0] cs_ones;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output tick_in, btn_start_stop, btn_clear, btn_lap,
    input  min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones,
    input  running, lap_active, overflow
  );

  modport slave (
    input  tick_in, btn_start_stop, btn_clear, btn_lap,
    output min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch core: synchronises tick and buttons, runs the IDLE/RUN/PAUSE
// control FSM and keeps an MM:SS.CC BCD count with a lap-freeze display.
module stopwatch_counter #(
  parameter int MAX_MIN     = 59,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  stopwatch_counter_if.slave sw
);

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);
  localparam int         N_IN         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] pulse;
  logic            tick_pulse, ss_pulse, clr_pulse, lap_pulse;

  // Digit index 0 = cs_ones ... 5 = min_tens.
  logic [3:0] cnt_reg  [6];
  logic [3:0] cnt_next [6];
  logic [3:0] cnt_inc  [6];
  logic [3:0] disp_reg [6];
  logic [3:0] disp_next[6];

  logic lap_reg, lap_next;
  logic ovf_reg, ovf_next;
  logic do_inc, do_clear;
  logic wrap, carry;

  assign raw_in = {sw.btn_lap, sw.btn_clear, sw.btn_start_stop, sw.tick_in};

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   prev_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= '0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
          prev_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign pulse[gi] = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  endgenerate

  assign tick_pulse = pulse[0];
  assign ss_pulse   = pulse[1];
  assign clr_pulse  = pulse[2];
  assign lap_pulse  = pulse[3];

  // Control FSM: start_stop has priority over clear in PAUSE.
  always_comb begin
    state_next = state_reg;
    do_inc     = 1'b0;
    do_clear   = 1'b0;
    lap_next   = lap_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ss_pulse) state_next = ST_RUN;
      end
      ST_RUN: begin
        do_inc = tick_pulse;
        if (lap_pulse) lap_next = ~lap_reg;
        if (ss_pulse) state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (ss_pulse) begin
          state_next = ST_RUN;
        end else if (clr_pulse) begin
          state_next = ST_IDLE;
          do_clear   = 1'b1;
          lap_next   = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // BCD ripple increment across all digits in a single cycle.
  always_comb begin
    cnt_inc = cnt_reg;
    wrap    = 1'b0;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_reg[i] == ((i == 3) ? 4'd5 : 4'd9)) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_reg[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    if (carry) begin
      if (cnt_reg[5] == MAX_MIN_TENS && cnt_reg[4] == MAX_MIN_ONES) begin
        cnt_inc[4] = 4'd0;
        cnt_inc[5] = 4'd0;
        wrap       = 1'b1;
      end else if (cnt_reg[4] == 4'd9) begin
        cnt_inc[4] = 4'd0;
        cnt_inc[5] = cnt_reg[5] + 4'd1;
      end else begin
        cnt_inc[4] = cnt_reg[4] + 4'd1;
      end
    end
  end

  // The lap snapshot captures the count as it stands after this cycle's tick.
  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (do_clear) begin
      cnt_next = '{default: 4'd0};
      ovf_next = 1'b0;
    end else if (do_inc) begin
      cnt_next = cnt_inc;
      if (wrap) ovf_next = 1'b1;
    end
    if (!lap_next || !lap_reg) begin
      disp_next = cnt_next;
    end else begin
      disp_next = disp_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '{default: 4'd0};
      disp_reg  <= '{default: 4'd0};
      lap_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      disp_reg  <= disp_next;
      lap_reg   <= lap_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign sw.cs_ones    = disp_reg[0];
  assign sw.cs_tens    = disp_reg[1];
  assign sw.sec_ones   = disp_reg[2];
  assign sw.sec_tens   = disp_reg[3];
  assign sw.min_ones   = disp_reg[4];
  assign sw.min_tens   = disp_reg[5];
  assign sw.running    = (state_reg == ST_RUN);
  assign sw.lap_active = lap_reg;
  assign sw.overflow   = ovf_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (MAX_MIN=59 and MAX_MIN=1) share
// stimulus; a centisecond-level model is compared every cycle plus literal checks.
module tb_stopwatch_counter;

  localparam int SYNC    = 2;
  localparam int LIMIT_A = (59 + 1) * 6000;
  localparam int LIMIT_B = (1 + 1) * 6000;

  localparam logic [3:0] M_TICK = 4'b0001;
  localparam logic [3:0] M_SS   = 4'b0010;
  localparam logic [3:0] M_CLR  = 4'b0100;
  localparam logic [3:0] M_LAP  = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_counter_if sw_a ();
  stopwatch_counter_if sw_b ();

  assign sw_b.tick_in        = sw_a.tick_in;
  assign sw_b.btn_start_stop = sw_a.btn_start_stop;
  assign sw_b.btn_clear      = sw_a.btn_clear;
  assign sw_b.btn_lap        = sw_a.btn_lap;

  stopwatch_counter #(.MAX_MIN(59), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst(rst), .sw(sw_a.slave)
  );
  stopwatch_counter #(.MAX_MIN(1), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst), .sw(sw_b.slave)
  );

  logic [23:0] disp_a, disp_b;
  logic [2:0]  flags_a, flags_b;
  assign disp_a  = {sw_a.min_tens, sw_a.min_ones, sw_a.sec_tens, sw_a.sec_ones, sw_a.cs_tens, sw_a.cs_ones};
  assign disp_b  = {sw_b.min_tens, sw_b.min_ones, sw_b.sec_tens, sw_b.sec_ones, sw_b.cs_tens, sw_b.cs_ones};
  assign flags_a = {sw_a.running, sw_a.lap_active, sw_a.overflow};
  assign flags_b = {sw_b.running, sw_b.lap_active, sw_b.overflow};

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: counts are plain centisecond totals; state is 0=idle 1=run 2=pause.
  int       m_state;
  bit       m_lap;
  int       m_cnt  [2];
  int       m_snap [2];
  bit       m_ovf  [2];
  bit [3:0] m_hist [0:SYNC];
  bit       model_valid = 1'b0;

  function automatic logic [23:0] to_bcd(int v);
    int mm, ss, cc;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_step();
    bit [3:0] cur;
    bit [3:0] p;
    int       lim [2];
    lim[0] = LIMIT_A;
    lim[1] = LIMIT_B;
    cur = {sw_a.btn_lap, sw_a.btn_clear, sw_a.btn_start_stop, sw_a.tick_in};
    if (rst) begin
      m_state = 0;
      m_lap   = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_snap[k] = 0; m_ovf[k] = 1'b0;
      end
      for (int k = 0; k <= SYNC; k++) m_hist[k] = 4'b0;
      model_valid = 1'b1;
      return;
    end
    // An input seen high at edge n-SYNC but low at n-SYNC-1 takes effect now.
    p = m_hist[SYNC-1] & ~m_hist[SYNC];
    for (int k = SYNC; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = cur;
    case (m_state)
      0: if (p[1]) m_state = 1;
      1: begin
        if (p[0]) begin
          for (int k = 0; k < 2; k++) begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == lim[k]) begin
              m_cnt[k] = 0;
              m_ovf[k] = 1'b1;
            end
          end
        end
        if (p[3]) begin
          m_lap = !m_lap;
          if (m_lap) begin
            m_snap[0] = m_cnt[0];
            m_snap[1] = m_cnt[1];
          end
        end
        if (p[1]) m_state = 2;
      end
      default: begin
        if (p[1]) begin
          m_state = 1;
        end else if (p[2]) begin
          m_state = 0;
          m_lap   = 1'b0;
          for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 1'b0;
          end
        end
      end
    endcase
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (model_valid) begin
        check("model_a_digits", disp_a, to_bcd(m_lap ? m_snap[0] : m_cnt[0]));
        check("model_a_flags", flags_a, {m_state == 1, m_lap, m_ovf[0]});
        check("model_b_digits", disp_b, to_bcd(m_lap ? m_snap[1] : m_cnt[1]));
        check("model_b_flags", flags_b, {m_state == 1, m_lap, m_ovf[1]});
      end
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic [3:0] m);
    {sw_a.btn_lap, sw_a.btn_clear, sw_a.btn_start_stop, sw_a.tick_in} = m;
    @(negedge clk);
    {sw_a.btn_lap, sw_a.btn_clear, sw_a.btn_start_stop, sw_a.tick_in} = 4'b0;
    wait_cycles(4);
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      sw_a.tick_in = 1'b1;
      @(negedge clk);
      sw_a.tick_in = 1'b0;
      @(negedge clk);
    end
    wait_cycles(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  task automatic expect_a(string tag, logic [23:0] d, logic [2:0] f);
    check({tag, "_a_digits"}, disp_a, d);
    check({tag, "_a_flags"}, flags_a, f);
    $display("[%0t] %s: A=%06h run/lap/ovf=%03b (want %06h %03b)", $time, tag, disp_a, flags_a, d, f);
  endtask

  task automatic expect_b(string tag, logic [23:0] d, logic [2:0] f);
    check({tag, "_b_digits"}, disp_b, d);
    check({tag, "_b_flags"}, flags_b, f);
    $display("[%0t] %s: B=%06h run/lap/ovf=%03b (want %06h %03b)", $time, tag, disp_b, flags_b, d, f);
  endtask

  initial begin
    {sw_a.btn_lap, sw_a.btn_clear, sw_a.btn_start_stop, sw_a.tick_in} = 4'b0;
    rst = 1'b1;
    wait_cycles(3);
    expect_a("reset", 24'h000000, 3'b000);
    expect_b("reset", 24'h000000, 3'b000);
    rst = 1'b0;
    wait_cycles(2);

    press(M_SS);
    ticks(150);
    expect_a("run150", 24'h000150, 3'b100);
    ticks(849);
    expect_a("at_9_99", 24'h000999, 3'b100);
    ticks(1);
    expect_a("carry_10_00", 24'h001000, 3'b100);

    do_reset();
    press(M_SS);
    ticks(42);
    press(M_SS);
    expect_a("paused_42", 24'h000042, 3'b000);
    ticks(5);
    expect_a("pause_ticks", 24'h000042, 3'b000);
    press(M_CLR);
    expect_a("cleared", 24'h000000, 3'b000);

    press(M_SS);
    ticks(10);
    expect_a("run10", 24'h000010, 3'b100);
    press(M_CLR);
    expect_a("clr_in_run", 24'h000010, 3'b100);
    press(M_SS);
    press(M_SS | M_CLR);
    expect_a("ss_clr_pause", 24'h000010, 3'b100);

    ticks(190);
    expect_a("at_2_00", 24'h000200, 3'b100);
    press(M_LAP);
    expect_a("lap_on", 24'h000200, 3'b110);
    ticks(300);
    expect_a("lap_frozen", 24'h000200, 3'b110);
    press(M_LAP);
    expect_a("lap_off", 24'h000500, 3'b100);

    press(M_LAP);
    press(M_SS);
    expect_a("lap_in_pause", 24'h000500, 3'b010);
    press(M_LAP);
    expect_a("lap_ign_pause", 24'h000500, 3'b010);
    press(M_SS);
    press(M_LAP);
    expect_a("lap_rel_run", 24'h000500, 3'b100);

    press(M_TICK | M_SS);
    expect_a("tick_stop_run", 24'h000501, 3'b000);
    press(M_TICK | M_SS);
    expect_a("tick_start_pause", 24'h000501, 3'b100);

    do_reset();
    press(M_SS);
    ticks(11999);
    expect_a("pre_wrap", 24'h015999, 3'b100);
    expect_b("pre_wrap", 24'h015999, 3'b100);
    ticks(1);
    expect_a("no_wrap_59", 24'h020000, 3'b100);
    expect_b("wrap", 24'h000000, 3'b101);
    ticks(5);
    expect_b("ovf_sticky", 24'h000005, 3'b101);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_a("rst_mid_run", 24'h000000, 3'b000);
    expect_b("rst_mid_run", 24'h000000, 3'b000);
    wait_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
